penc_rr_arbiter_4req: RTL and testbench

Sequential round-robin arbiter that shares one resource among four requesters. Each cycle it priority-encodes the 4-bit request vector from a rotating start point into a one-hot grant and a 2-bit encoded index. A grant is held while its requester keeps requesting, up to a parameterised hold limit. The block sits in front of any shared datapath resource whose users present a raw request vector and expect a registered one-hot/encoded grant.

---
 rtl/penc_rr_arbiter_4req_if.sv | 11 +
 rtl/penc_rr_arbiter_4req.sv | 94 +++++++++
 tb/tb_penc_rr_arbiter_4req.sv | 119 +++++++++++
 3 files changed

// File: rtl/penc_rr_arbiter_4req_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface penc_rr_arbiter_4req_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_val;

  modport master (output req, input gnt, gnt_idx, gnt_val);
  modport slave  (input req, output gnt, gnt_idx, gnt_val);
endinterface

// File: rtl/penc_rr_arbiter_4req.sv
// Four-way round-robin arbiter with a bounded grant hold time.
// Grant outputs are registered; release and re-arbitration happen on the same edge.
module penc_rr_arbiter_4req #(
  parameter int unsigned MAX_HOLD = 4  // legal range 1..15
) (
  input  logic                         clk,
  input  logic                         reset,
  penc_rr_arbiter_4req_if.slave        bus
);

  typedef enum logic {IDLE, BUSY} mode_t;

  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

  mode_t      r_mode;
  logic [1:0] r_ptr;
  logic [1:0] r_cur;
  logic [3:0] r_cnt;
  logic [3:0] r_gnt;
  logic [1:0] r_gnt_idx;
  logic       r_gnt_val;

  mode_t      w_mode_nxt;
  logic [1:0] w_ptr_nxt;
  logic [1:0] w_cur_nxt;
  logic [3:0] w_cnt_nxt;
  logic       w_rel;
  logic [2:0] w_arb;

  // Returns {found, index}; offsets are scanned highest first so the
  // lowest offset from ptr is written last and wins.
  function automatic logic [2:0] f_arb(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_mode_nxt = r_mode;
    w_cur_nxt  = r_cur;
    w_cnt_nxt  = r_cnt;
    w_rel      = (r_mode == BUSY) && (!bus.req[r_cur] || (r_cnt == HOLD_LIM));
    w_ptr_nxt  = w_rel ? r_cur + 2'd1 : r_ptr;
    // Arbitrate with the post-release pointer so handoff has no idle bubble.
    w_arb      = f_arb(bus.req, w_ptr_nxt);

    if ((r_mode == IDLE) || w_rel) begin
      if (w_arb[2]) begin
        w_mode_nxt = BUSY;
        w_cur_nxt  = w_arb[1:0];
        w_cnt_nxt  = 4'd1;
      end else begin
        w_mode_nxt = IDLE;
        w_cnt_nxt  = 4'd0;
      end
    end else begin
      w_cnt_nxt = r_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_mode    <= IDLE;
      r_ptr     <= 2'd0;
      r_cur     <= 2'd0;
      r_cnt     <= 4'd0;
      r_gnt     <= 4'b0000;
      r_gnt_idx <= 2'd0;
      r_gnt_val <= 1'b0;
    end else begin
      r_mode    <= w_mode_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cur     <= w_cur_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gnt     <= (w_mode_nxt == BUSY) ? (4'b0001 << w_cur_nxt) : 4'b0000;
      r_gnt_idx <= (w_mode_nxt == BUSY) ? w_cur_nxt : 2'd0;
      r_gnt_val <= (w_mode_nxt == BUSY);
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_idx = r_gnt_idx;
  assign bus.gnt_val = r_gnt_val;

endmodule

// File: tb/tb_penc_rr_arbiter_4req.sv
// Directed bench for penc_rr_arbiter_4req (MAX_HOLD=4) with an expectation
// queue: each step pushes the grant it expects after the next rising edge.
module tb_penc_rr_arbiter_4req;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       val;
  } exp_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;
  exp_t sb_q[$];

  penc_rr_arbiter_4req_if bus ();

  penc_rr_arbiter_4req #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk_exp(input logic [3:0] g);
    exp_t e;
    e.gnt = g;
    e.val = (g != 4'b0000);
    case (g)
      4'b0010: e.idx = 2'd1;
      4'b0100: e.idx = 2'd2;
      4'b1000: e.idx = 2'd3;
      default: e.idx = 2'd0;
    endcase
    return e;
  endfunction

  // Drive req/reset for one cycle, queue the expectation, compare after the edge.
  task automatic step(input string tag, input logic rs, input logic [3:0] r,
                      input logic [3:0] exp_gnt);
    exp_t want;
    exp_t got;
    @(negedge clk);
    reset   = rs;
    bus.req = r;
    sb_q.push_back(mk_exp(exp_gnt));
    @(posedge clk);
    #1;
    got  = '{gnt: bus.gnt, idx: bus.gnt_idx, val: bus.gnt_val};
    want = sb_q.pop_front();
    n_cmp++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got gnt=%b idx=%0d val=%b, expected gnt=%b idx=%0d val=%b",
             tag, got.gnt, got.idx, got.val, want.gnt, want.idx, want.val);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    reset   = 1'b1;
    bus.req = 4'b0000;

    // Idle after reset
    step("reset", 1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++) step("idle", 1'b0, 4'b0000, 4'b0000);

    // Hold-limit handoff between requesters 0 and 2
    step("rst_hold", 1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) step("hold_r0_a", 1'b0, 4'b0101, 4'b0001);
    for (int i = 0; i < 4; i++) step("hold_r2",   1'b0, 4'b0101, 4'b0100);
    for (int i = 0; i < 2; i++) step("hold_r0_b", 1'b0, 4'b0101, 4'b0001);

    // Sole requester re-granted at the cap without a bubble
    step("rst_sole", 1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 10; i++) step("sole_r3", 1'b0, 4'b1000, 4'b1000);

    // Full rotation with all four requesting
    step("rst_rot", 1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) step("rot_r0", 1'b0, 4'b1111, 4'b0001);
    for (int i = 0; i < 4; i++) step("rot_r1", 1'b0, 4'b1111, 4'b0010);
    for (int i = 0; i < 4; i++) step("rot_r2", 1'b0, 4'b1111, 4'b0100);
    for (int i = 0; i < 4; i++) step("rot_r3", 1'b0, 4'b1111, 4'b1000);
    for (int i = 0; i < 4; i++) step("rot_r0_again", 1'b0, 4'b1111, 4'b0001);

    // Early release moves ptr to 2, so 0 beats 1 on the next request
    step("rst_early", 1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 2; i++) step("early_r1", 1'b0, 4'b0010, 4'b0010);
    step("early_drop", 1'b0, 4'b0000, 4'b0000);
    step("early_ptr2", 1'b0, 4'b0011, 4'b0001);

    // Reset mid-grant restores ptr to 0
    step("rst_mid", 1'b1, 4'b0000, 4'b0000);
    step("mid_r1",    1'b0, 4'b0010, 4'b0010);
    step("mid_r2",    1'b0, 4'b0100, 4'b0100);
    step("mid_reset", 1'b1, 4'b1001, 4'b0000);
    step("mid_ptr0",  1'b0, 4'b1001, 4'b0001);

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
